exec_trace_buffer: RTL and testbench
====================================

EXEC_TRACE_BUFFER -- requirements
Module: exec_trace_buffer

Interface
REQ-001 Parameter DEPTH, default 16, number of trace entries held (power of two, 2..256).
REQ-002 Parameter STALL_LIMIT, default 8, consecutive unchanged-PC cycles that signal halt (1..255).
REQ-003 Port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 Port reset  input  1  asynchronous active-low reset (0 = reset asserted).
REQ-005 Port capture_en  input  1  enables trace sampling this cycle.
REQ-006 Port pc_in  input  16  processor pc_out.
REQ-007 Port result_in  input  16  processor alu_result.
REQ-008 Port rd_data  output  32  head entry: {pc[15:0], result[15:0]}.
REQ-009 Port rd_valid  output  1  head entry present.
REQ-010 Port rd_ready  input  1  consumer accepts head entry.
REQ-011 Port count  output  log2(DEPTH)+1  entries currently stored.
REQ-012 Port overflow_cnt  output  8  entries dropped because the buffer was full.
REQ-013 Port halted  output  1  processor judged halted.

Function
REQ-014 Block SHALL run a three-state FSM: IDLE (no sample taken yet), ARMED, HALTED.
REQ-015 IDLE: first cycle with capture_en=1 SHALL sample unconditionally, load last_pc<=pc_in, and move to ARMED.
REQ-016 ARMED/HALTED: capture_en=1 and pc_in!=last_pc SHALL sample, load last_pc<=pc_in, clear stall counter.
REQ-017 ARMED/HALTED: capture_en=1 and pc_in==last_pc SHALL not sample and SHALL increment the 8-bit stall counter, saturating at 255.
REQ-018 capture_en=0 SHALL take no sample and hold last_pc, stall counter and FSM state.
REQ-019 ARMED->HALTED on the edge where the stall counter reaches STALL_LIMIT; halted SHALL equal (state==HALTED), registered.
REQ-020 HALTED->ARMED on the edge where a PC-change sample is taken (REQ-016); halted drops the same edge.
REQ-021 A sample SHALL push {pc_in, result_in} into a DEPTH-entry circular FIFO; pointers wrap modulo DEPTH.
REQ-022 rd_valid SHALL equal (count!=0); rd_data SHALL show the head entry combinationally (show-ahead), and SHALL be 0 when empty.
REQ-023 Pop SHALL occur when rd_valid && rd_ready; rd_ready while empty SHALL have no effect.
REQ-024 Push when full with no pop SHALL drop the sample, leave FIFO contents unchanged, and increment overflow_cnt, saturating at 255.
REQ-025 Simultaneous push and pop when full SHALL accept the push; count unchanged, no overflow increment.
REQ-026 Simultaneous push and pop when not empty SHALL leave count unchanged; when empty, push only (count becomes 1).
REQ-027 Sample-to-rd_valid latency SHALL be one cycle (entry visible after the capturing edge).
REQ-028 last_pc and the stall counter SHALL update even when the push is dropped by REQ-024.

Reset
REQ-029 reset=0 SHALL immediately (without clk) force: state=IDLE, count=0, rd_valid=0, rd_data=0, overflow_cnt=0, halted=0, stall counter=0, last_pc=0, pointers=0.
REQ-030 FIFO storage contents need not be cleared; they SHALL be unobservable after reset because rd_data is gated by rd_valid.
REQ-031 Reset asserted mid-operation SHALL discard all entries and the halt state; the first capture_en=1 cycle after release SHALL follow REQ-015 even if pc_in equals the pre-reset last_pc.
REQ-032 Reset deassertion SHALL be sampled synchronously; the first edge with reset=1 already performs normal operation.

Verification
REQ-033 Reset release, capture_en=1, pc_in=0x0000,0x0002,0x0004 with result_in=0x1111,0x2222,0x3333, rd_ready=0 -> count=3, rd_data=0x00001111, rd_valid=1.
REQ-034 DEPTH=16, 18 distinct PCs with rd_ready=0 -> count=16, overflow_cnt=2, entries hold first 16 samples; then one push with rd_ready=1 while full -> count=16, overflow_cnt=2.
REQ-035 pc_in held at 0x0010 with capture_en=1 -> halted=1 after the 8th repeat edge (STALL_LIMIT=8); pc_in=0x0012 next -> halted=0, new entry {0x0012,result}.
REQ-036 capture_en=0 for 20 cycles with constant pc_in after arming -> halted stays 0, count unchanged.
REQ-037 Reset pulsed low mid-stream with count=5, overflow_cnt=3, halted=1 -> all outputs zero at once; first post-reset sample taken even with pc_in equal to the old last_pc.
REQ-038 Random pc_in/capture_en/rd_ready for 10,000 cycles against a queue model -> popped data order, count, overflow_cnt and halted match exactly.

Source files
------------

// File: rtl/exec_trace_buffer.sv
// Execution trace buffer: samples {pc, result} on PC change into a show-ahead FIFO
// and flags the processor as halted once the PC sits still for STALL_LIMIT samples.
module exec_trace_buffer #(
    parameter int DEPTH       = 16,
    parameter int STALL_LIMIT = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     capture_en,
    input  logic [15:0]              pc_in,
    input  logic [15:0]              result_in,
    output logic [31:0]              rd_data,
    output logic                     rd_valid,
    input  logic                     rd_ready,
    output logic [$clog2(DEPTH):0]   count,
    output logic [7:0]               overflow_cnt,
    output logic                     halted
);

    localparam int AW = $clog2(DEPTH);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ARMED  = 2'd1;
    localparam logic [1:0] ST_HALTED = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [15:0]   last_pc_q, last_pc_d;
    logic [7:0]    stall_q, stall_d;
    logic          halted_q, halted_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic [7:0]    ovf_q, ovf_d;

    logic [31:0]   mem [DEPTH];

    logic sample;
    logic full;
    logic pop;
    logic push_ok;

    // Sampling / halt detection
    always_comb begin
        state_d   = state_q;
        last_pc_d = last_pc_q;
        stall_d   = stall_q;
        sample    = 1'b0;
        if (capture_en) begin
            if (state_q == ST_IDLE || pc_in != last_pc_q) begin
                sample    = 1'b1;
                last_pc_d = pc_in;
                stall_d   = 8'd0;
                state_d   = ST_ARMED;
            end else begin
                if (stall_q != 8'hFF) stall_d = stall_q + 8'd1;
                if (state_q == ST_ARMED && stall_d == STALL_LIMIT[7:0]) state_d = ST_HALTED;
            end
        end
        halted_d = (state_d == ST_HALTED);
    end

    // FIFO bookkeeping; a pop frees a slot in the same cycle, so full+pop still accepts
    always_comb begin
        full     = (count_q == (AW+1)'(DEPTH));
        pop      = (count_q != '0) && rd_ready;
        push_ok  = sample && (!full || pop);
        wr_ptr_d = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q;
        if (push_ok && !pop)      count_d = count_q + (AW+1)'(1);
        else if (!push_ok && pop) count_d = count_q - (AW+1)'(1);
        ovf_d = ovf_q;
        if (sample && full && !pop && ovf_q != 8'hFF) ovf_d = ovf_q + 8'd1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            last_pc_q <= 16'd0;
            stall_q   <= 8'd0;
            halted_q  <= 1'b0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            ovf_q     <= 8'd0;
        end else begin
            state_q   <= state_d;
            last_pc_q <= last_pc_d;
            stall_q   <= stall_d;
            halted_q  <= halted_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            ovf_q     <= ovf_d;
        end
    end

    // Storage is not reset; stale contents are hidden by the rd_valid gate below
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr_q] <= {pc_in, result_in};
    end

    assign rd_valid     = (count_q != '0);
    assign rd_data      = rd_valid ? mem[rd_ptr_q] : 32'd0;
    assign count        = count_q;
    assign overflow_cnt = ovf_q;
    assign halted       = halted_q;

endmodule

// File: tb/tb_exec_trace_buffer.sv
// Randomized + directed bench for exec_trace_buffer with a queue-based reference model
// and a scoreboard monitor that checks every popped entry.
module tb_exec_trace_buffer;

    localparam int DEPTH       = 16;
    localparam int STALL_LIMIT = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        capture_en = 1'b0;
    logic [15:0] pc_in = 16'd0;
    logic [15:0] result_in = 16'd0;
    logic        rd_ready = 1'b0;
    logic [31:0] rd_data;
    logic        rd_valid;
    logic [4:0]  count;
    logic [7:0]  overflow_cnt;
    logic        halted;

    exec_trace_buffer #(.DEPTH(DEPTH), .STALL_LIMIT(STALL_LIMIT)) dut (
        .clk(clk), .reset(reset), .capture_en(capture_en), .pc_in(pc_in),
        .result_in(result_in), .rd_data(rd_data), .rd_valid(rd_valid),
        .rd_ready(rd_ready), .count(count), .overflow_cnt(overflow_cnt), .halted(halted)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Reference model: the trace is a list of samples; halt means "stalled long enough".
    bit          m_started;
    logic [15:0] m_lpc;
    int          m_stall;
    int          m_ovf;
    logic [31:0] m_q[$];
    logic [31:0] exp_q[$];

    function automatic bit m_halted();
        return m_started && (m_stall >= STALL_LIMIT);
    endfunction

    task automatic model_reset();
        m_started = 1'b0;
        m_lpc     = 16'd0;
        m_stall   = 0;
        m_ovf     = 0;
        m_q.delete();
        exp_q.delete();
    endtask

    task automatic model_edge();
        bit samp;
        bit pop;
        samp = 1'b0;
        pop  = (m_q.size() != 0) && rd_ready;
        if (capture_en) begin
            if (!m_started || pc_in != m_lpc) begin
                samp      = 1'b1;
                m_started = 1'b1;
                m_lpc     = pc_in;
                m_stall   = 0;
            end else if (m_stall < 255) begin
                m_stall++;
            end
        end
        if (pop) void'(m_q.pop_front());
        if (samp) begin
            if (m_q.size() < DEPTH) begin
                m_q.push_back({pc_in, result_in});
                exp_q.push_back({pc_in, result_in});
            end else if (m_ovf < 255) begin
                m_ovf++;
            end
        end
    endtask

    task automatic step(input logic ce, input logic [15:0] pc, input logic [15:0] res, input logic rdy);
        capture_en = ce;
        pc_in      = pc;
        result_in  = res;
        rd_ready   = rdy;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic reset_pulse();
        capture_en = 1'b0;
        rd_ready   = 1'b0;
        reset      = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
    endtask

    // Monitor: every cycle compare state to the model and pop the scoreboard on a handshake
    initial begin
        forever begin
            @(negedge clk);
            chk("count", 32'(count), 32'(m_q.size()));
            chk("overflow_cnt", 32'(overflow_cnt), 32'(m_ovf));
            chk("halted", 32'(halted), 32'(m_halted()));
            chk("rd_valid", 32'(rd_valid), 32'(m_q.size() != 0));
            if (rd_valid && rd_ready) begin
                if (exp_q.size() == 0) chk("pop_unexpected", 32'd1, 32'd0);
                else chk("pop_data", rd_data, exp_q.pop_front());
            end else if (!rd_valid) begin
                chk("rd_data_empty", rd_data, 32'd0);
            end
        end
    end

    initial begin
        logic [15:0] pc;
        logic [15:0] last;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_rd_valid", 32'(rd_valid), 32'd0);
        chk("rst_rd_data", rd_data, 32'd0);
        chk("rst_ovf", 32'(overflow_cnt), 32'd0);
        chk("rst_halted", 32'(halted), 32'd0);
        reset = 1'b1;

        // Three basic samples
        step(1'b1, 16'h0000, 16'h1111, 1'b0);
        step(1'b1, 16'h0002, 16'h2222, 1'b0);
        step(1'b1, 16'h0004, 16'h3333, 1'b0);
        chk("basic_count", 32'(count), 32'd3);
        chk("basic_head", rd_data, 32'h0000_1111);
        chk("basic_valid", 32'(rd_valid), 32'd1);

        // Overflow and full push+pop
        reset_pulse();
        for (int i = 0; i < 18; i++) step(1'b1, 16'h0100 + 16'(2*i), 16'(i), 1'b0);
        chk("full_count", 32'(count), 32'd16);
        chk("full_ovf", 32'(overflow_cnt), 32'd2);
        chk("full_head", rd_data, 32'h0100_0000);
        step(1'b1, 16'h0300, 16'h00AA, 1'b1);
        chk("fullpp_count", 32'(count), 32'd16);
        chk("fullpp_ovf", 32'(overflow_cnt), 32'd2);
        chk("fullpp_head", rd_data, 32'h0102_0001);
        for (int i = 0; i < 16; i++) step(1'b0, 16'h0300, 16'h0, 1'b1);
        chk("drain_count", 32'(count), 32'd0);

        // Stall detection
        step(1'b1, 16'h0010, 16'h00AA, 1'b0);
        for (int k = 1; k <= 8; k++) begin
            step(1'b1, 16'h0010, 16'h00AA, 1'b0);
            chk("stall_halt", 32'(halted), 32'(k == 8));
        end
        step(1'b1, 16'h0012, 16'hBEEF, 1'b0);
        chk("unhalt", 32'(halted), 32'd0);
        chk("unhalt_count", 32'(count), 32'd2);
        step(1'b0, 16'h0012, 16'h0, 1'b1);
        chk("unhalt_entry", rd_data, 32'h0012_BEEF);
        step(1'b0, 16'h0012, 16'h0, 1'b1);

        // capture_en low holds everything
        step(1'b1, 16'h0020, 16'h0001, 1'b0);
        for (int i = 0; i < 20; i++) step(1'b0, 16'h0020, 16'h0001, 1'b0);
        chk("hold_halted", 32'(halted), 32'd0);
        chk("hold_count", 32'(count), 32'd1);

        // Mid-stream asynchronous reset
        reset_pulse();
        for (int i = 0; i < 19; i++) step(1'b1, 16'h0200 + 16'(2*i), 16'(i), 1'b0);
        for (int i = 0; i < 11; i++) step(1'b0, 16'h0, 16'h0, 1'b1);
        last = 16'h0200 + 16'd36;
        for (int i = 0; i < 8; i++) step(1'b1, last, 16'h5555, 1'b0);
        chk("pre_rst_count", 32'(count), 32'd5);
        chk("pre_rst_ovf", 32'(overflow_cnt), 32'd3);
        chk("pre_rst_halted", 32'(halted), 32'd1);
        capture_en = 1'b0;
        rd_ready   = 1'b0;
        reset      = 1'b0;
        model_reset();
        #1;
        chk("async_count", 32'(count), 32'd0);
        chk("async_valid", 32'(rd_valid), 32'd0);
        chk("async_data", rd_data, 32'd0);
        chk("async_ovf", 32'(overflow_cnt), 32'd0);
        chk("async_halted", 32'(halted), 32'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        step(1'b1, last, 16'h7777, 1'b0);
        chk("post_rst_count", 32'(count), 32'd1);
        chk("post_rst_head", rd_data, {last, 16'h7777});

        // Random soak
        reset_pulse();
        pc = 16'h0;
        for (int i = 0; i < 10000; i++) begin
            if ($urandom_range(0, 4) == 0) pc = 16'($urandom_range(0, 7) * 2);
            step(($urandom_range(0, 9) < 8), pc, 16'($urandom), ($urandom_range(0, 9) < 4));
        end
        for (int i = 0; i < 20; i++) step(1'b0, pc, 16'h0, 1'b1);
        chk("final_count", 32'(count), 32'd0);
        chk("final_sb_empty", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
